// File: rtl/phase_corr_pkg.sv
// Shared types and constants for the phase corrector.
//   phase_corr_entry_t    : one offset-table entry {en, offset}
//   PHASE_CORR_INIT_ENTRY : value written into every entry after reset
//   PHASE_CORR_TBL_W      : stored entry width (9 with PHASE_CORR_MASK_EN, else 8)
//   phase_corr_state_t    : control FSM states
package phase_corr_pkg;

  localparam int PHASE_CORR_DEPTH = 249;

  typedef struct packed {
    logic       en;
    logic [7:0] offset;
  } phase_corr_entry_t;

  localparam phase_corr_entry_t PHASE_CORR_INIT_ENTRY = '{en: 1'b1, offset: 8'h00};

`ifdef PHASE_CORR_MASK_EN
  localparam int PHASE_CORR_TBL_W = 9;
`else
  localparam int PHASE_CORR_TBL_W = 8;
`endif

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RUN} phase_corr_state_t;

endpackage

// File: rtl/phase_corr_table.sv
// Offset table: simple dual-port RAM, one write port and one registered
// read port. Read-first: a same-cycle write to the address being read
// returns the old contents. Writes to addresses >= DEPTH are dropped.
//   clk    : clock
//   we     : write strobe;  waddr / wdata : write address / data
//   raddr  : read address;  rdata         : read data, one cycle later
//            (reads at or beyond DEPTH return 0)
module phase_corr_table
  import phase_corr_pkg::*;
#(
  parameter int DEPTH = PHASE_CORR_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = PHASE_CORR_TBL_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Both ports sample the array before the write lands -> read-first.
  always_ff @(posedge clk) begin
    if (we && (waddr < LIMIT)) mem[waddr] <= wdata;
    if (raddr < LIMIT) rdata_q <= mem[raddr];
    else               rdata_q <= '0;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/phase_corrector.sv
// Per-transducer phase offset / output mask stage between modulation and
// silencer. Each burst of DEPTH samples (sample k = transducer k) gets the
// stored offset for its transducer added to the phase, with 2-cycle latency
// and no backpressure.
// Optional build macro: PHASE_CORR_MASK_EN (store the enable bit and zero
// the intensity of disabled transducers).
// Ports:
//   CLK, RESET (async, active high)
//   CORR_ENABLE              : correction on/off, sampled at burst start
//   DIN_VALID, INTENSITY_IN, PHASE_IN : input samples
//   TBL_WE, TBL_ADDR, TBL_DATA        : table write port ({en, offset})
//   ERR_CLR                  : clears ERR
//   INTENSITY_OUT, PHASE_OUT, DOUT_VALID : corrected samples
//   BUSY                     : table initialisation in progress
//   ERR                      : sticky burst-length error
module phase_corrector
  import phase_corr_pkg::*;
#(
  parameter int DEPTH = PHASE_CORR_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CORR_ENABLE,
  input  logic          DIN_VALID,
  input  logic [15:0]   INTENSITY_IN,
  input  logic [7:0]    PHASE_IN,
  input  logic          TBL_WE,
  input  logic [AW-1:0] TBL_ADDR,
  input  logic [8:0]    TBL_DATA,
  input  logic          ERR_CLR,
  output logic [15:0]   INTENSITY_OUT,
  output logic [7:0]    PHASE_OUT,
  output logic          DOUT_VALID,
  output logic          BUSY,
  output logic          ERR
);

  localparam int            TW   = PHASE_CORR_TBL_W;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL = AW'(DEPTH);

  phase_corr_state_t state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              corr_q, corr_d;
  logic              err_q, err_d;
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  logic [7:0]        phase_s1_q, phase_s1_d, phase_out_q, phase_out_d;
  logic [15:0]       int_s1_q, int_s1_d, int_out_q, int_out_d;
  logic              use_s1_q, use_s1_d;

  logic              set_err, use_tbl, tbl_we;
  logic [AW-1:0]     tbl_waddr;
  logic [TW-1:0]     tbl_wdata, tbl_rdata;
  logic [7:0]        rd_off;

  // Control FSM and sample index. idx doubles as the INIT fill address.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    corr_d  = corr_q;
    set_err = 1'b0;
    use_tbl = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (idx_q == LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        idx_d = '0;
        // Only a rising DIN_VALID opens a burst, so the tail of a burst
        // that started during INIT is passed through unchecked.
        if (DIN_VALID && !vld_pipe_q[1]) begin
          state_d = ST_RUN;
          idx_d   = AW'(1);
          corr_d  = CORR_ENABLE;
          use_tbl = CORR_ENABLE;
        end
      end
      ST_RUN: begin
        if (DIN_VALID) begin
          // Samples past DEPTH bypass the table and flag the overrun.
          use_tbl = corr_q && (idx_q != FULL);
          if (idx_q == FULL) set_err = 1'b1;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          idx_d   = '0;
          if (idx_q != FULL) set_err = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Table write mux: INIT owns the port, bus writes are ignored meanwhile.
  always_comb begin
    tbl_we    = TBL_WE;
    tbl_waddr = TBL_ADDR;
`ifdef PHASE_CORR_MASK_EN
    tbl_wdata = TBL_DATA;
`else
    tbl_wdata = TBL_DATA[7:0];
`endif
    if (state_q == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = idx_q;
`ifdef PHASE_CORR_MASK_EN
      tbl_wdata = PHASE_CORR_INIT_ENTRY;
`else
      tbl_wdata = PHASE_CORR_INIT_ENTRY.offset;
`endif
    end
  end

  phase_corr_table #(.DEPTH(DEPTH), .AW(AW), .W(TW)) u_table (
    .clk   (CLK),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (idx_q),
    .rdata (tbl_rdata)
  );

`ifdef PHASE_CORR_MASK_EN
  phase_corr_entry_t rd_entry;
  assign rd_entry = tbl_rdata;
  assign rd_off   = rd_entry.offset;
  assign int_out_d = (use_s1_q && !rd_entry.en) ? 16'h0000 : int_s1_q;
`else
  logic unused_tbl_en;
  assign unused_tbl_en = TBL_DATA[8];
  assign rd_off        = tbl_rdata;
  assign int_out_d     = int_s1_q;
`endif

  // Stage 1 registers the sample alongside the table read; stage 2 applies it.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[1], DIN_VALID};
    phase_s1_d  = PHASE_IN;
    int_s1_d    = INTENSITY_IN;
    use_s1_d    = use_tbl;
    phase_out_d = phase_s1_q + (use_s1_q ? rd_off : 8'h00);
    err_d       = err_q;
    if (ERR_CLR) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      corr_q      <= 1'b0;
      err_q       <= 1'b0;
      vld_pipe_q  <= '0;
      phase_s1_q  <= '0;
      int_s1_q    <= '0;
      use_s1_q    <= 1'b0;
      phase_out_q <= '0;
      int_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      corr_q      <= corr_d;
      err_q       <= err_d;
      vld_pipe_q  <= vld_pipe_d;
      phase_s1_q  <= phase_s1_d;
      int_s1_q    <= int_s1_d;
      use_s1_q    <= use_s1_d;
      phase_out_q <= phase_out_d;
      int_out_q   <= int_out_d;
    end
  end

  assign INTENSITY_OUT = int_out_q;
  assign PHASE_OUT     = phase_out_q;
  assign DOUT_VALID    = vld_pipe_q[2];
  assign BUSY          = (state_q == ST_INIT);
  assign ERR           = err_q;

endmodule

// File: tb/tb_phase_corrector.sv
module tb_phase_corrector;

  localparam int DEPTH = 249;
`ifdef PHASE_CORR_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, CORR_ENABLE, DIN_VALID, TBL_WE, ERR_CLR;
  logic [15:0] INTENSITY_IN;
  logic [7:0]  PHASE_IN, TBL_ADDR;
  logic [8:0]  TBL_DATA;
  logic [15:0] INTENSITY_OUT;
  logic [7:0]  PHASE_OUT;
  logic        DOUT_VALID, BUSY, ERR;

  phase_corrector dut (
    .CLK(CLK), .RESET(RESET), .CORR_ENABLE(CORR_ENABLE), .DIN_VALID(DIN_VALID),
    .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN), .TBL_WE(TBL_WE),
    .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA), .ERR_CLR(ERR_CLR),
    .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT), .DOUT_VALID(DOUT_VALID),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0]  out_ph  [256];
  logic [15:0] out_int [256];
  logic [7:0]  exp_ph  [256];
  logic [15:0] exp_int [256];
  int out_cnt = 0, first_out = 0, in_cyc = 0;

  always @(negedge CLK) begin
    if (DOUT_VALID) begin
      if (out_cnt == 0) first_out = cyc;
      if (out_cnt < 256) begin
        out_ph[out_cnt]  = PHASE_OUT;
        out_int[out_cnt] = INTENSITY_OUT;
      end
      out_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_exp(input logic [7:0] ph, input logic [15:0] inten);
    for (int i = 0; i < 256; i++) begin
      exp_ph[i]  = ph;
      exp_int[i] = inten;
    end
  endtask

  task automatic check_burst(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n && i < 256; i++)
      if (out_ph[i] !== exp_ph[i] || out_int[i] !== exp_int[i]) begin
        if (bad < 4)
          $display("  %s sample %0d: ph %0h/%0h int %0h/%0h", tag, i,
                   out_ph[i], exp_ph[i], out_int[i], exp_int[i]);
        bad++;
      end
    chk({tag, "_bad"}, bad, 0);
    chk({tag, "_cnt"}, out_cnt, n);
    chk({tag, "_lat"}, first_out - in_cyc, 2);
  endtask

  // wr_idx >= 0 issues a table write in the same cycle as that sample.
  task automatic burst(input int n, input logic [7:0] ph, input logic [15:0] inten,
                       input logic ce, input logic tog, input int wr_idx,
                       input logic [7:0] wr_addr, input logic [8:0] wr_data);
    out_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      if (n > DEPTH && i == DEPTH) chk("err_before_ovf", ERR, 0);
      if (i == 0) in_cyc = cyc;
      DIN_VALID    = 1'b1;
      PHASE_IN     = ph;
      INTENSITY_IN = inten;
      CORR_ENABLE  = (tog && i > 0) ? ~ce : ce;
      TBL_WE       = (i == wr_idx);
      TBL_ADDR     = wr_addr;
      TBL_DATA     = wr_data;
    end
    @(posedge CLK); #1;
    if (n > DEPTH) chk("err_at_ovf", ERR, 1);
    DIN_VALID = 1'b0;
    TBL_WE    = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [8:0] data);
    @(posedge CLK); #1;
    TBL_WE = 1'b1; TBL_ADDR = addr; TBL_DATA = data;
    @(posedge CLK); #1;
    TBL_WE = 1'b0;
  endtask

  task automatic release_and_init(input string tag);
    int cnt;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    cnt = 0;
    while (BUSY && cnt < 1000) begin
      cnt++;
      @(negedge CLK);
    end
    chk(tag, cnt, 249);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; CORR_ENABLE = 1'b0; DIN_VALID = 1'b0; TBL_WE = 1'b0; ERR_CLR = 1'b0;
    INTENSITY_IN = '0; PHASE_IN = '0; TBL_ADDR = '0; TBL_DATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_int", INTENSITY_OUT, 0);
    chk("rst_ph", PHASE_OUT, 0);
    chk("rst_dv", DOUT_VALID, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_err", ERR, 0);
    release_and_init("busy_cycles");

    // Fresh table: pass-through of 0x10.
    fill_exp(8'h10, 16'h1234);
    burst(DEPTH, 8'h10, 16'h1234, 1'b1, 1'b0, -1, 8'h00, 9'h000);
    check_burst("b_init", DEPTH);
    chk("b_init_err", ERR, 0);

    // Offset 0x20 at 5 wraps 0xF0 to 0x10.
    wr(8'd5, 9'h120);
    fill_exp(8'hF0, 16'h1234);
    exp_ph[5] = 8'h10;
    burst(DEPTH, 8'hF0, 16'h1234, 1'b1, 1'b0, -1, 8'h00, 9'h000);
    check_burst("b_wrap", DEPTH);
    chk("b_wrap_s5", out_ph[5], 8'h10);
    chk("b_wrap_s4", out_ph[4], 8'hF0);

    // Disable transducer 7.
    wr(8'd7, 9'h000);
    fill_exp(8'h00, 16'hFFFF);
    exp_ph[5] = 8'h20;
    exp_int[7] = MASK ? 16'h0000 : 16'hFFFF;
    burst(DEPTH, 8'h00, 16'hFFFF, 1'b1, 1'b0, -1, 8'h00, 9'h000);
    check_burst("b_mask", DEPTH);
    chk("b_mask_s7", out_int[7], MASK ? 16'h0000 : 16'hFFFF);

    // Write addr 3 while sample 3 reads it: old offset (0) applies.
    fill_exp(8'h00, 16'hABCD);
    exp_ph[5] = 8'h20;
    exp_int[7] = MASK ? 16'h0000 : 16'hABCD;
    burst(DEPTH, 8'h00, 16'hABCD, 1'b1, 1'b0, 3, 8'd3, 9'h140);
    check_burst("b_rf", DEPTH);
    chk("b_rf_s3", out_ph[3], 8'h00);

    // Out-of-range write ignored; the addr-3 write is now visible.
    wr(8'd249, 9'h0FF);
    fill_exp(8'h00, 16'hABCD);
    exp_ph[3] = 8'h40; exp_ph[5] = 8'h20;
    exp_int[7] = MASK ? 16'h0000 : 16'hABCD;
    burst(DEPTH, 8'h00, 16'hABCD, 1'b1, 1'b0, -1, 8'h00, 9'h000);
    check_burst("b_oor", DEPTH);
    chk("b_oor_s3", out_ph[3], 8'h40);

    // CORR_ENABLE 0 then toggled: whole burst is pass-through.
    fill_exp(8'hF0, 16'hFFFF);
    burst(DEPTH, 8'hF0, 16'hFFFF, 1'b0, 1'b1, -1, 8'h00, 9'h000);
    check_burst("b_tog0", DEPTH);

    // CORR_ENABLE 1 then toggled: whole burst corrected.
    fill_exp(8'hF0, 16'hFFFF);
    exp_ph[3] = 8'h30; exp_ph[5] = 8'h10;
    exp_int[7] = MASK ? 16'h0000 : 16'hFFFF;
    burst(DEPTH, 8'hF0, 16'hFFFF, 1'b1, 1'b1, -1, 8'h00, 9'h000);
    check_burst("b_tog1", DEPTH);
    chk("b_tog1_err", ERR, 0);

    // Short burst.
    fill_exp(8'h00, 16'h0001);
    exp_ph[3] = 8'h40; exp_ph[5] = 8'h20;
    exp_int[7] = MASK ? 16'h0000 : 16'h0001;
    burst(100, 8'h00, 16'h0001, 1'b1, 1'b0, -1, 8'h00, 9'h000);
    check_burst("b_short", 100);
    chk("short_err", ERR, 1);
    @(posedge CLK); #1; ERR_CLR = 1'b1;
    @(posedge CLK); #1; ERR_CLR = 1'b0;
    chk("err_clr", ERR, 0);

    // Long burst: sample 250 flags ERR and passes unchanged.
    fill_exp(8'hF0, 16'h5555);
    exp_ph[3] = 8'h30; exp_ph[5] = 8'h10;
    exp_int[7] = MASK ? 16'h0000 : 16'h5555;
    burst(DEPTH + 1, 8'hF0, 16'h5555, 1'b1, 1'b0, -1, 8'h00, 9'h000);
    check_burst("b_long", DEPTH + 1);
    chk("long_s250", out_ph[DEPTH], 8'hF0);
    chk("long_err_hold", ERR, 1);
    @(posedge CLK); #1; ERR_CLR = 1'b1;
    @(posedge CLK); #1; ERR_CLR = 1'b0;

    // Reset mid-burst.
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      DIN_VALID = 1'b1; PHASE_IN = 8'h77; INTENSITY_IN = 16'h7777; CORR_ENABLE = 1'b1;
    end
    @(negedge CLK);
    chk("mid_dv_pre", DOUT_VALID, 1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_dv", DOUT_VALID, 0);
    chk("mid_ph", PHASE_OUT, 0);
    chk("mid_busy", BUSY, 1);
    chk("mid_err", ERR, 0);
    DIN_VALID = 1'b0;
    release_and_init("busy_cycles2");

    // Table back to defaults after re-init.
    fill_exp(8'h00, 16'hFFFF);
    burst(DEPTH, 8'h00, 16'hFFFF, 1'b1, 1'b0, -1, 8'h00, 9'h000);
    check_burst("b_reinit", DEPTH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
